// File: rtl/multi_tick_timer.sv
// multi_tick_timer: CH independent timebase channels sharing one clock.
// Each channel has a runtime-loadable period, periodic / one-shot mode,
// enable and clear. It exposes a combinational terminal flag (tick_c), a
// registered one-cycle tick (tick_q), an armed flag (busy) and its live count.
//
// Optional feature macro: TMR_PRESCALE_EN
//   defined   -> a shared prescaler divides the advance rate by PRESCALE
//   undefined -> channels advance on every clk (PRESCALE is ignored)
//
// A period of P cycles counts 0..P-1; P=0 behaves as P=1.
module multi_tick_timer #(
    parameter int CH         = 2,
    parameter int CW         = 16,
    parameter int DEF_PERIOD = 20,
    parameter int PRESCALE   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CH-1:0]      en,
    input  logic [CH-1:0]      clr,
    input  logic [CH-1:0]      load,
    input  logic [CH-1:0]      mode,
    input  logic [CH*CW-1:0]   period,
    output logic [CH-1:0]      tick_c,
    output logic [CH-1:0]      tick_q,
    output logic [CH-1:0]      busy,
    output logic [CH*CW-1:0]   count
);

    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] DEF_P = CW'(DEF_PERIOD);

    // Elaboration-time parameter sanity checks.
    if (CH < 1 || CH > 8) begin : g_bad_ch
        $error("multi_tick_timer: CH must be 1..8");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("multi_tick_timer: PRESCALE must be >= 1");
    end

    // Shared advance strobe; every channel qualifies its advance with it.
    logic w_stb;

`ifdef TMR_PRESCALE_EN
    localparam int              PW       = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;

    // Free-running prescaler cycling 0..PRESCALE-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    assign w_stb = (r_pre == PRE_LAST);
`else
    assign w_stb = 1'b1;
`endif

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [CW-1:0] r_count;
        logic [CW-1:0] r_period;
        logic          r_mode;
        logic          r_busy;
        logic          r_tick_q;

        logic [CW-1:0] w_last;
        logic          w_adv;
        logic          w_term;

        // A zero period is treated as one, so the terminal count is 0 either way.
        assign w_last = (r_period == '0) ? '0 : (r_period - ONE);
        assign w_adv  = en[gi] & r_busy & w_stb;
        assign w_term = w_adv & (r_count == w_last);

        // Per-channel state update with priority clr > load > terminal > advance.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_count  <= '0;
                r_period <= DEF_P;
                r_mode   <= 1'b0;
                r_busy   <= 1'b1;
                r_tick_q <= 1'b0;
            end else if (clr[gi]) begin
                // One-shot channels stay disarmed after a clear until reloaded.
                r_count  <= '0;
                r_tick_q <= 1'b0;
                r_busy   <= ~r_mode;
            end else if (load[gi]) begin
                // Reload always restarts the count and drops any pending tick.
                r_period <= period[gi*CW +: CW];
                r_mode   <= mode[gi];
                r_count  <= '0;
                r_busy   <= 1'b1;
                r_tick_q <= 1'b0;
            end else if (w_term) begin
                r_count  <= '0;
                r_tick_q <= 1'b1;
                if (r_mode) begin
                    r_busy <= 1'b0;
                end
            end else if (w_adv) begin
                r_count  <= r_count + ONE;
                r_tick_q <= 1'b0;
            end else begin
                r_tick_q <= 1'b0;
            end
        end

        assign tick_c[gi]          = w_term;
        assign tick_q[gi]          = r_tick_q;
        assign busy[gi]            = r_busy;
        assign count[gi*CW +: CW]  = r_count;
    end

endmodule

// File: tb/tb_multi_tick_timer.sv
// Bench for multi_tick_timer: directed scenarios followed by random traffic.
// A behavioural model predicts outputs each cycle into a scoreboard queue;
// a separate monitor pops and compares on the falling edge.
module tb_multi_tick_timer;

    localparam int CH   = 2;
    localparam int CW   = 8;
    localparam int DEFP = 20;
    localparam int PRE  = 4;
`ifdef TMR_PRESCALE_EN
    localparam int M_PRE = PRE;
`else
    localparam int M_PRE = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CH-1:0]    en, clr, load, mode;
    logic [CH*CW-1:0] period;
    logic [CH-1:0]    tick_c, tick_q, busy;
    logic [CH*CW-1:0] count;

    always #5 clk = ~clk;

    multi_tick_timer #(
        .CH(CH), .CW(CW), .DEF_PERIOD(DEFP), .PRESCALE(PRE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .mode(mode), .period(period), .tick_c(tick_c), .tick_q(tick_q),
        .busy(busy), .count(count)
    );

    typedef struct packed {
        logic [CH-1:0]    tc;
        logic [CH-1:0]    tq;
        logic [CH-1:0]    bz;
        logic [CH*CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cyc   = 0;

    // Reference model: count as number of advances modulo the effective period.
    int   m_cnt[CH];
    int   m_per[CH];
    logic m_mode[CH];
    logic m_busy[CH];
    logic m_tq[CH];
    int   m_pre;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i]  = 0;
            m_per[i]  = DEFP;
            m_mode[i] = 1'b0;
            m_busy[i] = 1'b1;
            m_tq[i]   = 1'b0;
        end
        m_pre = 0;
    endtask

    // Drive one cycle of inputs, predict outputs, advance the model, wait an edge.
    task automatic step(input logic r, input logic [1:0] e, input logic [1:0] c,
                        input logic [1:0] l, input logic [1:0] md,
                        input logic [CW-1:0] p0, input logic [CW-1:0] p1);
        exp_t x;
        logic stb, adv, term;
        int   peff, pin;
        #1;
        rst_n  = r;
        en     = e;
        clr    = c;
        load   = l;
        mode   = md;
        period = {p1, p0};
        stb = (m_pre == M_PRE - 1);
        for (int i = 0; i < CH; i++) begin
            peff = (m_per[i] == 0) ? 1 : m_per[i];
            adv  = e[i] && m_busy[i] && stb;
            term = adv && (((m_cnt[i] + 1) % peff) == 0);
            x.tc[i] = term;
            x.tq[i] = m_tq[i];
            x.bz[i] = m_busy[i];
            x.cnt[i*CW +: CW] = CW'(m_cnt[i]);
            pin = (i == 0) ? int'(p0) : int'(p1);
            if (!r) begin
                m_cnt[i] = 0; m_per[i] = DEFP; m_mode[i] = 1'b0;
                m_busy[i] = 1'b1; m_tq[i] = 1'b0;
            end else if (c[i]) begin
                m_cnt[i] = 0; m_tq[i] = 1'b0; m_busy[i] = !m_mode[i];
            end else if (l[i]) begin
                m_per[i] = pin; m_mode[i] = md[i]; m_cnt[i] = 0;
                m_busy[i] = 1'b1; m_tq[i] = 1'b0;
            end else if (adv) begin
                m_cnt[i] = (m_cnt[i] + 1) % peff;
                m_tq[i]  = term;
                if (term && m_mode[i]) m_busy[i] = 1'b0;
            end else begin
                m_tq[i] = 1'b0;
            end
        end
        sb.push_back(x);
        m_pre = r ? ((m_pre + 1) % M_PRE) : 0;
        @(posedge clk);
    endtask

    task automatic idle(input int n, input logic [1:0] e);
        for (int k = 0; k < n; k++) step(1'b1, e, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
    endtask

    // Monitor: compare DUT outputs against the oldest prediction, away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cyc++;
                n_tests++;
                if (tick_c !== e.tc) begin
                    n_fail++;
                    $display("FAIL tick_c cycle %0d: got %b expected %b", n_cyc, tick_c, e.tc);
                end
                n_tests++;
                if (tick_q !== e.tq) begin
                    n_fail++;
                    $display("FAIL tick_q cycle %0d: got %b expected %b", n_cyc, tick_q, e.tq);
                end
                n_tests++;
                if (busy !== e.bz) begin
                    n_fail++;
                    $display("FAIL busy cycle %0d: got %b expected %b", n_cyc, busy, e.bz);
                end
                n_tests++;
                if (count !== e.cnt) begin
                    n_fail++;
                    $display("FAIL count cycle %0d: got %h expected %h", n_cyc, count, e.cnt);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] re, rc, rl, rm;
        logic [CW-1:0] rp0, rp1;
        logic rr;
        rst_n = 1'b0; en = '0; clr = '0; load = '0; mode = '0; period = '0;
        repeat (3) @(posedge clk);
        model_reset();

        // Reset state with counting disabled.
        idle(3, 2'b00);
        // Default period on both channels.
        idle(50, 2'b11);
        // Channel 0 to period 5, periodic.
        step(1'b1, 2'b11, 2'b00, 2'b01, 2'b00, 8'd5, 8'd0);
        idle(17, 2'b11);
        // Channel 1 one-shot period 3, then re-armed by a second load.
        step(1'b1, 2'b11, 2'b00, 2'b10, 2'b10, 8'd0, 8'd3);
        idle(8 * M_PRE, 2'b11);
        step(1'b1, 2'b11, 2'b00, 2'b10, 2'b10, 8'd0, 8'd3);
        idle(8 * M_PRE, 2'b11);
        // Freeze channel 0 at count 2 for 7 cycles.
        for (int k = 0; k < 10 * M_PRE && m_cnt[0] != 2; k++) idle(1, 2'b11);
        idle(7, 2'b10);
        idle(8 * M_PRE, 2'b11);
        // clr and load together at count 3: clr wins, period kept.
        for (int k = 0; k < 10 * M_PRE && m_cnt[0] != 3; k++) idle(1, 2'b11);
        step(1'b1, 2'b11, 2'b01, 2'b01, 2'b00, 8'd9, 8'd0);
        idle(12 * M_PRE, 2'b11);
        // Period 0 ticks on every advance.
        step(1'b1, 2'b11, 2'b00, 2'b01, 2'b00, 8'd0, 8'd0);
        idle(6 * M_PRE, 2'b11);
        // Mid-period reset.
        idle(3, 2'b11);
        step(1'b0, 2'b11, 2'b01, 2'b10, 2'b11, 8'd4, 8'd4);
        idle(5, 2'b11);

        // Randomized traffic.
        for (int k = 0; k < 2500; k++) begin
            rr = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < CH; i++) begin
                re[i] = ($urandom_range(0, 9) != 0);
                rc[i] = ($urandom_range(0, 39) == 0);
                rl[i] = ($urandom_range(0, 24) == 0);
                rm[i] = $urandom_range(0, 1) != 0;
            end
            rp0 = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 255)) : CW'($urandom_range(0, 9));
            rp1 = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 255)) : CW'($urandom_range(0, 9));
            step(rr, re, rc, rl, rm, rp0, rp1);
        end

        repeat (3) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
